// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT machine-timer slave.
// Holds the bus address map, the read response codes and the handshake FSM states.
package clint_pkg;

  localparam logic [31:0] MTIME_LO_ADDR = 32'ha000_0048;
  localparam logic [31:0] MTIME_HI_ADDR = 32'ha000_004c;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

endpackage

// File: rtl/clint_mtime_counter.sv
// Free-running 64-bit machine timer.
// Advances once every TICK_DIV clock cycles and wraps silently at 2^64.
module clint_mtime_counter #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] mtime
);

  localparam int unsigned      PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] prescale;
  logic [63:0]      count;
  logic             tick;

  // With TICK_DIV = 1 the prescaler is pinned at zero, so every cycle ticks.
  assign tick = (prescale == PRE_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescale <= '0;
      count    <= '0;
    end else if (tick) begin
      prescale <= '0;
      count    <= count + 64'd1;
    end else begin
      prescale <= prescale + PRE_W'(1);
    end
  end

  assign mtime = count;

endmodule

// File: rtl/clint_mtime.sv
// Read-only AXI4-Lite-style slave exposing mtime as two 32-bit words.
// Address decode and a two-state read handshake; no write channel.
module clint_mtime #(
  parameter logic [31:0] MTIME_LO_ADDR = clint_pkg::MTIME_LO_ADDR,
  parameter logic [31:0] MTIME_HI_ADDR = clint_pkg::MTIME_HI_ADDR,
  parameter int unsigned TICK_DIV      = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid
);

  import clint_pkg::*;

  logic [63:0] mtime;
  logic [31:0] rdata_next;
  logic [1:0]  rresp_next;
  state_e      state;

  clint_mtime_counter #(
    .TICK_DIV (TICK_DIV)
  ) u_counter (
    .clock (clock),
    .reset (reset),
    .mtime (mtime)
  );

  // NOTE: defaults first so every path assigns both outputs and no latch forms.
  always_comb begin
    rdata_next = '0;
    rresp_next = RESP_SLVERR;
    if (araddr == MTIME_LO_ADDR) begin
      rdata_next = mtime[31:0];
      rresp_next = RESP_OKAY;
    end else if (araddr == MTIME_HI_ADDR) begin
      rdata_next = mtime[63:32];
      rresp_next = RESP_OKAY;
    end
  end

  // Handshake outputs are registered alongside the state so they never glitch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (arvalid && arready) begin
            rdata   <= rdata_next;
            rresp   <= rresp_next;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          // Data stays frozen until the master accepts it, even as mtime runs on.
          if (rvalid && rready) begin
            arready <= 1'b1;
            rvalid  <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clint_mtime.sv
// Directed bench for clint_mtime: reset, latency, carry, backpressure, decode errors
// and a divided tick rate, all against hand-computed values.
module tb_clint_mtime;

  localparam logic [31:0] LO  = 32'ha000_0048;
  localparam logic [31:0] HI  = 32'ha000_004c;
  localparam logic [31:0] BAD = 32'ha000_0050;

  logic        clock;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;

  logic [31:0] araddr4;
  logic        arvalid4;
  logic        arready4;
  logic        rready4;
  logic [31:0] rdata4;
  logic [1:0]  rresp4;
  logic        rvalid4;

  int checks;
  int errors;

  logic [31:0] d;
  logic [1:0]  r;
  logic [31:0] d1;
  logic [31:0] d2;

  clint_mtime dut (
    .clock   (clock),
    .reset   (reset),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rready  (rready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid)
  );

  clint_mtime #(
    .TICK_DIV (4)
  ) dut4 (
    .clock   (clock),
    .reset   (reset),
    .araddr  (araddr4),
    .arvalid (arvalid4),
    .arready (arready4),
    .rready  (rready4),
    .rdata   (rdata4),
    .rresp   (rresp4),
    .rvalid  (rvalid4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issues one read with rready high; returns one cycle after the R handshake.
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    araddr  = addr;
    arvalid = 1'b1;
    rready  = 1'b1;
    @(posedge clock); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("read_rvalid", rvalid, 1'b1);
    data = rdata;
    resp = rresp;
    @(posedge clock); #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    araddr   = '0;
    arvalid  = 1'b0;
    rready   = 1'b0;
    araddr4  = '0;
    arvalid4 = 1'b0;
    rready4  = 1'b0;

    #1;
    check("reset_arready", arready, 1'b1);
    check("reset_rvalid", rvalid, 1'b0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_rresp", rresp, 2'b00);

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Enter RESP, then abort with an asynchronous reset mid-cycle.
    araddr  = LO;
    arvalid = 1'b1;
    rready  = 1'b0;
    @(posedge clock); #1;
    arvalid = 1'b0;
    check("pre_abort_rvalid", rvalid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_rvalid", rvalid, 1'b0);
    check("abort_arready", arready, 1'b1);
    @(posedge clock); #1;
    reset = 1'b0;

    // First edge after release captures mtime = 0.
    araddr  = LO;
    arvalid = 1'b1;
    rready  = 1'b1;
    @(posedge clock); #1;
    arvalid = 1'b0;
    check("post_reset_rvalid", rvalid, 1'b1);
    check("post_reset_lo", rdata, 32'd0);
    @(posedge clock); #1;

    // Fresh reset, 100 edges, then a read captures 100.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    araddr  = LO;
    arvalid = 1'b1;
    rready  = 1'b1;
    check("lat_arready", arready, 1'b1);
    check("lat_rvalid_before", rvalid, 1'b0);
    @(posedge clock); #1;
    arvalid = 1'b0;
    check("lat_rvalid", rvalid, 1'b1);
    check("lat_rdata", rdata, 32'd100);
    check("lat_rresp", rresp, 2'b00);
    @(posedge clock); #1;
    check("lat_rvalid_drop", rvalid, 1'b0);
    check("lat_arready_back", arready, 1'b1);

    // Backpressure: handshake captures 102, held for 20 cycles with arvalid up.
    araddr  = LO;
    arvalid = 1'b1;
    rready  = 1'b0;
    @(posedge clock); #1;
    araddr = HI;
    check("hold_rdata_first", rdata, 32'd102);
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      check("hold_rvalid", rvalid, 1'b1);
      check("hold_rdata", rdata, 32'd102);
      check("hold_arready", arready, 1'b0);
    end
    arvalid = 1'b0;
    rready  = 1'b1;
    @(posedge clock); #1;
    check("release_rvalid", rvalid, 1'b0);
    check("release_arready", arready, 1'b1);

    // Handshakes two cycles apart: 124, error, 128, then high word 0.
    do_read(LO, d, r);
    check("lo_a", d, 32'd124);
    check("lo_a_resp", r, 2'b00);
    do_read(BAD, d, r);
    check("bad_rdata", d, 32'd0);
    check("bad_rresp", r, 2'b10);
    do_read(LO, d, r);
    check("lo_b", d, 32'd128);
    check("lo_b_resp", r, 2'b00);
    do_read(HI, d, r);
    check("hi_zero", d, 32'd0);

    // Preload mtime just below the 32-bit carry.
    force dut.u_counter.count = 64'h0000_0000_ffff_fffe;
    #1;
    release dut.u_counter.count;
    do_read(LO, d, r);
    check("carry_lo_before", d, 32'hffff_fffe);
    do_read(HI, d, r);
    check("carry_hi", d, 32'd1);
    check("carry_hi_resp", r, 2'b00);
    do_read(LO, d, r);
    check("carry_lo_wrapped", d, 32'd2);
    check("carry_lo_resp", r, 2'b00);

    // Divided tick: handshakes 40 cycles apart differ by 10.
    araddr4  = LO;
    arvalid4 = 1'b1;
    rready4  = 1'b1;
    @(posedge clock); #1;
    arvalid4 = 1'b0;
    check("div_rvalid_a", rvalid4, 1'b1);
    d1 = rdata4;
    repeat (39) @(posedge clock);
    #1;
    check("div_rvalid_idle", rvalid4, 1'b0);
    arvalid4 = 1'b1;
    @(posedge clock); #1;
    arvalid4 = 1'b0;
    check("div_rvalid_b", rvalid4, 1'b1);
    d2 = rdata4;
    check("div_delta", d2 - d1, 32'd10);
    check("div_rresp", rresp4, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clint_mtime.md
Name: clint_mtime

Overview:
- Read-only, AXI4-Lite-style timer slave.
- Exposes a free-running 64-bit machine timer (mtime) as two 32-bit words at 0xa000_0048 (low) and 0xa000_004c (high).
- Sits behind the core's memory arbiter, which routes reads of exactly those two addresses to this block.
- Has no write channel.

Parameters:
- MTIME_LO_ADDR, 32'ha000_0048, byte address of mtime[31:0].
- MTIME_HI_ADDR, 32'ha000_004c, byte address of mtime[63:32].
- TICK_DIV, 1, clock cycles per mtime increment (must be >= 1).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- araddr  in  32  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rready  in  1  read data ready from the master.
- rdata  out  32  read data.
- rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- rvalid  out  1  read data valid.

Behaviour:

Reset (asynchronous, takes effect immediately):
- mtime = 0, prescale counter = 0.
- FSM = IDLE, arready = 1, rvalid = 0, rdata = 0, rresp = 2'b00.

mtime counter:
- Increments by 1 every TICK_DIV clock cycles, independent of bus activity.
- TICK_DIV = 1 means it increments every cycle.
- Wraps from 2^64-1 to 0 silently.
- The prescaler wraps from TICK_DIV-1 to 0 on each increment.

FSM has two states, IDLE and RESP:
- IDLE:
  - arready = 1, rvalid = 0.
  - On arvalid && arready: register rdata/rresp from the current mtime value (pre-increment value of that edge), go to RESP.
- RESP:
  - arready = 0, rvalid = 1.
  - rdata/rresp are held stable.
  - On rvalid && rready: go to IDLE; rvalid deasserts the next cycle.
  - Without rready: hold indefinitely; mtime keeps counting, but rdata does not change.

Latency:
- AR handshake in cycle N gives rvalid = 1 in cycle N+1.
- With rready already high, the next AR can be accepted in cycle N+2.

Address decode (full 32-bit compare):
- araddr == MTIME_LO_ADDR: rdata = mtime[31:0], rresp = OKAY.
- araddr == MTIME_HI_ADDR: rdata = mtime[63:32] of the same sampled value, rresp = OKAY.
- Any other address: rdata = 0, rresp = SLVERR.

Ordering and reset corner cases:
- There is no hardware atomicity between low and high reads. Software rereads high if a carry occurred.
- arvalid while in RESP is ignored; arready is 0, so the master holds.
- Reset asserted mid-transaction aborts it: rvalid drops immediately and mtime clears.

Decomposition:
- Shared package clint_pkg holds:
  - the address constants MTIME_LO_ADDR and MTIME_HI_ADDR;
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - the FSM state enum {IDLE, RESP}.
- One natural sub-module, clint_mtime_counter (64-bit counter with TICK_DIV prescaler, output mtime[63:0]).
- The top module holds the decode and the handshake FSM.

Test Plan:
- Reset mid-RESP: rvalid falls to 0 immediately (asynchronously), arready = 1; a following read of 0xa000_0048 returns a value below 10 with TICK_DIV = 1.
- Release reset, wait exactly 100 cycles, read 0xa000_0048 with rready held high: arready = 1 on the handshake cycle, rvalid = 1 the next cycle, rdata = the cycle count at the AR handshake (100 ± fixed offset, checked against a reference model), rresp = 0.
- Force mtime near 2^32 (with TICK_DIV = 1, run 2^32-2 cycles, or use a backdoor preload), read high then low: high = 1 after the carry, low wraps to small values, rresp = 0.
- Hold rready = 0 for 20 cycles after the AR handshake: rvalid stays 1, rdata is unchanged, and arready = 0 even with arvalid asserted; raising rready completes the read, and arready = 1 two cycles later.
- Read 0xa000_0050: rvalid = 1 next cycle, rdata = 0, rresp = 2'b10; mtime is unaffected.
- TICK_DIV = 4: two low reads 40 cycles apart differ by 10.
